// File: rtl/vga_timing_gen.sv
// Raster counter plus pin-side output stage. Sync and blank are carried through a
// delay line so that they line up with renderer pixels returning PIPE_DELAY cycles late.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 136,
    parameter int unsigned H_BP       = 160,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned V_FP       = 3,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BP       = 29,
    parameter int unsigned PIPE_DELAY = 3,
    parameter bit          SYNC_NEG   = 1'b1
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        blank_out,
    output logic        frame_start_out,
    input  logic [11:0] pixel_in,
    output logic [11:0] vga_rgb_out,
    output logic        vga_hs_out,
    output logic        vga_vs_out
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One bit wider than the counters so the sync-end sums cannot wrap.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_BLANK  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BLANK  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{blank: 1'b1, hs: 1'b0, vs: 1'b0};

    logic [11:0] h_wide;
    logic [10:0] v_wide;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic        blank_next;
    logic        frame_start_next;
    logic        hs_raw;
    logic        vs_raw;
    ctrl_t       pipe [PIPE_DELAY];
    ctrl_t       ctrl_last;

    assign h_wide    = {1'b0, hcount_out};
    assign v_wide    = {1'b0, vcount_out};
    assign ctrl_last = pipe[PIPE_DELAY-1];

    always_comb begin
        h_next = hcount_out + 11'd1;
        v_next = vcount_out;
        if (h_wide == H_LAST) begin
            h_next = '0;
            v_next = (v_wide == V_LAST) ? '0 : vcount_out + 10'd1;
        end
        blank_next       = ({1'b0, h_next} >= H_BLANK) || ({1'b0, v_next} >= V_BLANK);
        frame_start_next = (h_next == '0) && (v_next == '0);
        hs_raw           = (h_wide >= HS_START) && (h_wide < HS_END);
        vs_raw           = (v_wide >= VS_START) && (v_wide < VS_END);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_out      <= '0;
            vcount_out      <= '0;
            blank_out       <= 1'b0;
            frame_start_out <= 1'b1;
        end else begin
            hcount_out      <= h_next;
            vcount_out      <= v_next;
            blank_out       <= blank_next;
            frame_start_out <= frame_start_next;
        end
    end

    // Reset flushes every stage so no stale pixel can be released after reset.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= CTRL_IDLE;
            end
        end else begin
            pipe[0] <= '{blank: blank_out, hs: hs_raw, vs: vs_raw};
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            vga_rgb_out <= '0;
            vga_hs_out  <= SYNC_NEG;
            vga_vs_out  <= SYNC_NEG;
        end else begin
            vga_rgb_out <= ctrl_last.blank ? '0 : pixel_in;
            vga_hs_out  <= ctrl_last.hs ^ SYNC_NEG;
            vga_vs_out  <= ctrl_last.vs ^ SYNC_NEG;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three builds (small raster PD=3 active-low, small raster PD=8 active-high,
// full-size default) against a cycle-count raster model, with random pixels and resets.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pix = '0;

    always #5 clk = ~clk;

    logic [10:0] a_h, b_h, c_h;
    logic [9:0]  a_v, b_v, c_v;
    logic        a_bl, b_bl, c_bl, a_fs, b_fs, c_fs;
    logic [11:0] a_rgb, b_rgb, c_rgb;
    logic        a_hs, b_hs, c_hs, a_vs, b_vs, c_vs;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(3), .SYNC_NEG(1'b1)
    ) dut_a (
        .pixel_clk_in(clk), .rst_in(rst), .hcount_out(a_h), .vcount_out(a_v),
        .blank_out(a_bl), .frame_start_out(a_fs), .pixel_in(pix),
        .vga_rgb_out(a_rgb), .vga_hs_out(a_hs), .vga_vs_out(a_vs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(8), .SYNC_NEG(1'b0)
    ) dut_b (
        .pixel_clk_in(clk), .rst_in(rst), .hcount_out(b_h), .vcount_out(b_v),
        .blank_out(b_bl), .frame_start_out(b_fs), .pixel_in(pix),
        .vga_rgb_out(b_rgb), .vga_hs_out(b_hs), .vga_vs_out(b_vs)
    );

    vga_timing_gen dut_c (
        .pixel_clk_in(clk), .rst_in(rst), .hcount_out(c_h), .vcount_out(c_v),
        .blank_out(c_bl), .frame_start_out(c_fs), .pixel_in(pix),
        .vga_rgb_out(c_rgb), .vga_hs_out(c_hs), .vga_vs_out(c_vs)
    );

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
        logic        blank;
        logic        fs;
        logic        hs;
        logic        vs;
    } attr_t;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    bit valid  = 1'b0;
    int nh [0:15];

    // Raster position of the n-th cycle after reset, straight from the timing table.
    function automatic attr_t attr_of(input int cyc, input bit big);
        int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, h, v;
        attr_t a;
        if (big) begin
            ha = 1024; hf = 24; hsw = 136; hb = 160; va = 768; vf = 3; vsw = 6; vb = 29;
        end else begin
            ha = 16; hf = 2; hsw = 3; hb = 4; va = 10; vf = 1; vsw = 2; vb = 3;
        end
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h = cyc % ht;
        v = (cyc / ht) % vt;
        a.h     = h;
        a.v     = v;
        a.blank = (h >= ha) || (v >= va);
        a.fs    = (h == 0) && (v == 0);
        a.hs    = (h >= ha + hf) && (h < ha + hf + hsw);
        a.vs    = (v >= va + vf) && (v < va + vf + vsw);
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int pd, input bit sn, input bit big,
                             input logic [10:0] h, input logic [9:0] v, input logic bl,
                             input logic fs, input logic [11:0] rgb, input logic hs,
                             input logic vs);
        attr_t cur, old;
        logic  d_blank, d_hs, d_vs;
        cur = attr_of(n, big);
        chk({tag, "_hcount"}, 32'(h), cur.h);
        chk({tag, "_vcount"}, 32'(v), cur.v);
        chk({tag, "_blank"}, 32'(bl), 32'(cur.blank));
        chk({tag, "_frame_start"}, 32'(fs), 32'(cur.fs));
        if (n >= pd + 1) begin
            old     = attr_of(nh[pd+1], big);
            d_blank = old.blank;
            d_hs    = old.hs;
            d_vs    = old.vs;
        end else begin
            d_blank = 1'b1;
            d_hs    = 1'b0;
            d_vs    = 1'b0;
        end
        chk({tag, "_rgb"}, 32'(rgb), d_blank ? 32'd0 : 32'(pix));
        chk({tag, "_hs"}, 32'(hs), 32'(d_hs ^ sn));
        chk({tag, "_vs"}, 32'(vs), 32'(d_vs ^ sn));
    endtask

    // Compare process: inputs sampled at this edge are still stable 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            n     = 0;
            valid = 1'b1;
        end else if (valid) begin
            n++;
        end
        for (int i = 15; i > 0; i--) nh[i] = nh[i-1];
        nh[0] = n;
        if (valid) begin
            check_dut("a", 3, 1'b1, 1'b0, a_h, a_v, a_bl, a_fs, a_rgb, a_hs, a_vs);
            check_dut("b", 8, 1'b0, 1'b0, b_h, b_v, b_bl, b_fs, b_rgb, b_hs, b_vs);
            check_dut("c", 3, 1'b1, 1'b1, c_h, c_v, c_bl, c_fs, c_rgb, c_hs, c_vs);
            // Hand-computed anchors for the model.
            case (n)
                0:    begin chk("lit_a_fs0", 32'(a_fs), 1); chk("lit_a_hs_reset", 32'(a_hs), 1);
                            chk("lit_b_hs_reset", 32'(b_hs), 0); end
                3:    chk("lit_a_rgb_flushed", 32'(a_rgb), 0);
                24:   chk("lit_a_h24", 32'(a_h), 24);
                25:   begin chk("lit_a_wrap_h", 32'(a_h), 0); chk("lit_a_wrap_v", 32'(a_v), 1); end
                26:   chk("lit_b_hs_before", 32'(b_hs), 0);
                27:   chk("lit_b_hs_first", 32'(b_hs), 1);
                29:   chk("lit_b_hs_last", 32'(b_hs), 1);
                30:   chk("lit_b_hs_after", 32'(b_hs), 0);
                278:  chk("lit_a_vs_before", 32'(a_vs), 1);
                279:  chk("lit_a_vs_first", 32'(a_vs), 0);
                328:  chk("lit_a_vs_last", 32'(a_vs), 0);
                329:  chk("lit_a_vs_after", 32'(a_vs), 1);
                399:  begin chk("lit_a_last_v", 32'(a_v), 15); chk("lit_a_fs399", 32'(a_fs), 0); end
                400:  begin chk("lit_a_frame_h", 32'(a_h), 0); chk("lit_a_frame_fs", 32'(a_fs), 1); end
                1051: chk("lit_c_hs_before", 32'(c_hs), 1);
                1052: chk("lit_c_hs_first", 32'(c_hs), 0);
                1187: chk("lit_c_hs_last", 32'(c_hs), 0);
                1188: chk("lit_c_hs_after", 32'(c_hs), 1);
                1343: chk("lit_c_h1343", 32'(c_h), 1343);
                1344: begin chk("lit_c_wrap_h", 32'(c_h), 0); chk("lit_c_wrap_v", 32'(c_v), 1); end
                default: ;
            endcase
        end
    end

    initial begin
        int rst_left;
        for (int i = 0; i < 16; i++) nh[i] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Long uninterrupted run: several small frames and two full-size lines.
        for (int i = 0; i < 3000; i++) begin
            pix = 12'($urandom);
            @(negedge clk);
        end
        // Random mid-frame resets of 1..3 cycles.
        rst_left = 0;
        for (int i = 0; i < 6000; i++) begin
            pix = 12'($urandom);
            if (rst_left == 0 && $urandom_range(0, 299) == 0)
                rst_left = int'($urandom_range(1, 3));
            rst = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
